// File: rtl/rv32_shift_arbiter_if.sv
// Handshake bundle for rv32_shift_arbiter.
//   in0_* / in1_* : two requesters (valid/ready, 2-bit op, operand, shift amount, tag)
//   out_*         : one-entry result stage (valid/ready, shifted data, tag, source index)
// modport master : requester/consumer side (drives requests and out_ready)
// modport slave  : arbiter side (drives the readies and the result stage)
interface rv32_shift_arbiter_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in0_valid;
    logic             in0_ready;
    logic [1:0]       in0_op;
    logic [31:0]      in0_rs1;
    logic [4:0]       in0_shamt;
    logic [TAG_W-1:0] in0_tag;

    logic             in1_valid;
    logic             in1_ready;
    logic [1:0]       in1_op;
    logic [31:0]      in1_rs1;
    logic [4:0]       in1_shamt;
    logic [TAG_W-1:0] in1_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_src;

    modport master (
        output in0_valid, in0_op, in0_rs1, in0_shamt, in0_tag,
        output in1_valid, in1_op, in1_rs1, in1_shamt, in1_tag,
        output out_ready,
        input  in0_ready, in1_ready,
        input  out_valid, out_data, out_tag, out_src
    );

    modport slave (
        input  in0_valid, in0_op, in0_rs1, in0_shamt, in0_tag,
        input  in1_valid, in1_op, in1_rs1, in1_shamt, in1_tag,
        input  out_ready,
        output in0_ready, in1_ready,
        output out_valid, out_data, out_tag, out_src
    );
endinterface

// File: rtl/rv32_shift_arbiter.sv
// rv32_barrel_shifter: combinational 32-bit shifter.
//   enable     : 0 forces result to zero
//   immediate  : 1 takes the shift amount from code_bus[24:20] (I-type shamt field), else rs2[4:0]
//   code_bus   : instruction word
//   direction  : 0 left, 1 right
//   logical    : for right shifts, 1 zero-fills, 0 sign-fills
//   rs1, rs2   : operand and register shift amount
//   result     : shifted value
module rv32_barrel_shifter (
    input  logic        enable,
    input  logic        immediate,
    input  logic [31:0] code_bus,
    input  logic        direction,
    input  logic        logical,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] result
);
    logic [4:0] amount;
    logic       unused_bits;

    assign amount      = immediate ? code_bus[24:20] : rs2[4:0];
    assign unused_bits = ^{code_bus[31:25], code_bus[19:0], rs2[31:5]};

    always_comb begin
        result = '0;
        if (enable) begin
            if (!direction) begin
                result = rs1 << amount;
            end else if (logical) begin
                result = rs1 >> amount;
            end else begin
                result = 32'($signed(rs1) >>> amount);
            end
        end
    end
endmodule

// rv32_shift_arbiter: shares one barrel shifter between two requesters with
// round-robin arbitration and a one-entry registered result stage.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : rv32_shift_arbiter_if slave (two request channels, one result channel)
module rv32_shift_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32_shift_arbiter_if.slave  bus
);
    logic             ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_src_q, out_src_d;

    logic             can_accept;
    logic             ready0, ready1;
    logic             grant0, grant1;
    logic [1:0]       sel_op;
    logic [31:0]      sel_rs1;
    logic [4:0]       sel_shamt;
    logic [TAG_W-1:0] sel_tag;
    logic             direction, logical;
    logic [31:0]      shift_result;

    // Room in the output stage if it is empty or being drained this cycle.
    assign can_accept = !out_valid_q || bus.out_ready;

    // Ready depends only on the other requester's valid, never on its own.
    // Grants are held off while reset is asserted.
    assign ready0 = !rst && can_accept && (!ptr_q || !bus.in1_valid);
    assign ready1 = !rst && can_accept && (ptr_q || !bus.in0_valid);
    assign grant0 = ready0 && bus.in0_valid;
    assign grant1 = ready1 && bus.in1_valid;

    assign bus.in0_ready = ready0;
    assign bus.in1_ready = ready1;

    always_comb begin
        if (grant1) begin
            sel_op    = bus.in1_op;
            sel_rs1   = bus.in1_rs1;
            sel_shamt = bus.in1_shamt;
            sel_tag   = bus.in1_tag;
        end else begin
            sel_op    = bus.in0_op;
            sel_rs1   = bus.in0_rs1;
            sel_shamt = bus.in0_shamt;
            sel_tag   = bus.in0_tag;
        end
    end

    // Op decode; 2'b10 is folded into SLL.
    always_comb begin
        direction = 1'b0;
        logical   = 1'b1;
        unique case (sel_op)
            2'b01: begin
                direction = 1'b1;
                logical   = 1'b1;
            end
            2'b11: begin
                direction = 1'b1;
                logical   = 1'b0;
            end
            default: begin
                direction = 1'b0;
                logical   = 1'b1;
            end
        endcase
    end

    rv32_barrel_shifter u_shifter (
        .enable    (1'b1),
        .immediate (1'b0),
        .code_bus  (32'b0),
        .direction (direction),
        .logical   (logical),
        .rs1       (sel_rs1),
        .rs2       ({27'b0, sel_shamt}),
        .result    (shift_result)
    );

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_src_d   = out_src_q;
        if (grant0 || grant1) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_result;
            out_tag_d   = sel_tag;
            out_src_d   = grant1;
            // The granted requester hands priority to the other one.
            ptr_d       = !grant1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_src_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rv32_shift_arbiter.sv
// Directed bench for rv32_shift_arbiter: a reference arbiter/shift model runs
// beside the DUT, expected results are queued on each accepted transfer and
// compared when the result stage presents them.
module tb_rv32_shift_arbiter;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rv32_shift_arbiter_if #(.TAG_W(TAG_W)) bus ();

    rv32_shift_arbiter #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    result_t sb[$];
    logic    m_ptr   = 1'b0;
    logic    m_valid = 1'b0;
    logic    last_g0, last_g1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Bit-at-a-time reference shifter.
    function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] v,
                                                input logic [4:0] sh);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(sh)) begin
                if (op == 2'b01)      r = {1'b0, r[31:1]};
                else if (op == 2'b11) r = {r[31], r[31:1]};
                else                  r = {r[30:0], 1'b0};
            end
        end
        return r;
    endfunction

    task automatic drive0(input logic v, input logic [1:0] op, input logic [31:0] rs1,
                          input logic [4:0] sh, input logic [TAG_W-1:0] tag);
        bus.in0_valid = v; bus.in0_op = op; bus.in0_rs1 = rs1;
        bus.in0_shamt = sh; bus.in0_tag = tag;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [31:0] rs1,
                          input logic [4:0] sh, input logic [TAG_W-1:0] tag);
        bus.in1_valid = v; bus.in1_op = op; bus.in1_rs1 = rs1;
        bus.in1_shamt = sh; bus.in1_tag = tag;
    endtask

    // Compare current outputs with the model, update the model, advance one clock.
    task automatic step();
        logic    can, r0, r1;
        result_t e;
        #1;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 1'b0;
            sb.delete();
        end
        can = !m_valid || bus.out_ready;
        r0  = !rst && can && (!m_ptr || !bus.in1_valid);
        r1  = !rst && can && (m_ptr || !bus.in0_valid);
        check("in0_ready", 32'(bus.in0_ready), 32'(r0));
        check("in1_ready", 32'(bus.in1_ready), 32'(r1));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'(sb.size()), 32'd1);
            end else begin
                check("out_data", bus.out_data, sb[0].data);
                check("out_tag", 32'(bus.out_tag), 32'(sb[0].tag));
                check("out_src", 32'(bus.out_src), 32'(sb[0].src));
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
        last_g0 = r0 && bus.in0_valid;
        last_g1 = r1 && bus.in1_valid;
        if (last_g0) begin
            e.data = model_shift(bus.in0_op, bus.in0_rs1, bus.in0_shamt);
            e.tag  = bus.in0_tag;
            e.src  = 1'b0;
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = 1'b1;
        end else if (last_g1) begin
            e.data = model_shift(bus.in1_op, bus.in1_rs1, bus.in1_shamt);
            e.tag  = bus.in1_tag;
            e.src  = 1'b1;
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = 1'b0;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive0(1'b1, 2'b00, 32'h1234_5678, 5'd1, 4'd0);
        drive1(1'b1, 2'b00, 32'h1234_5678, 5'd1, 4'd0);
        bus.out_ready = 1'b1;

        // Reset: readies held low, outputs zero.
        step();
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_tag", 32'(bus.out_tag), 32'h0);
        check("rst_out_src", 32'(bus.out_src), 32'h0);
        step();
        rst = 1'b0;
        drive1(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);

        // SRA with sign fill, one-cycle latency.
        drive0(1'b1, 2'b11, 32'h8000_0000, 5'd4, 4'd3);
        step();
        drive0(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        check("sra_valid", 32'(bus.out_valid), 32'h1);
        check("sra_data", bus.out_data, 32'hF800_0000);
        check("sra_tag", 32'(bus.out_tag), 32'h3);
        check("sra_src", 32'(bus.out_src), 32'h0);
        step();

        // Requester 1 op variety, back to back.
        drive1(1'b1, 2'b01, 32'h8000_0000, 5'd4, 4'd1);
        step();
        check("srl_data", bus.out_data, 32'h0800_0000);
        drive1(1'b1, 2'b00, 32'h0000_0001, 5'd31, 4'd2);
        step();
        check("sll31_data", bus.out_data, 32'h8000_0000);
        drive1(1'b1, 2'b10, 32'h0000_0001, 5'd1, 4'd3);
        step();
        check("op10_data", bus.out_data, 32'h0000_0002);
        drive1(1'b1, 2'b11, 32'h9ABC_DEF0, 5'd0, 4'd4);
        step();
        check("sra0_data", bus.out_data, 32'h9ABC_DEF0);
        drive1(1'b1, 2'b01, 32'hCAFE_F00D, 5'd0, 4'd5);
        step();
        check("srl0_data", bus.out_data, 32'hCAFE_F00D);
        drive1(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        step();

        // Both valid continuously: alternate 0,1,0,1,0,1 from ptr=0.
        drive0(1'b1, 2'b00, 32'h0000_0011, 5'd2, 4'd0);
        drive1(1'b1, 2'b01, 32'h1100_0000, 5'd3, 4'd8);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_src", 32'(bus.out_src), 32'(i % 2));
            if (last_g0) drive0(1'b1, 2'b00, bus.in0_rs1 + 32'h10, 5'd2, bus.in0_tag + 4'd1);
            if (last_g1) drive1(1'b1, 2'b01, bus.in1_rs1 + 32'h100, 5'd3, bus.in1_tag + 4'd1);
        end
        drive0(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        drive1(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        step();

        // Stall for three cycles, then drain and refill in one cycle.
        drive0(1'b1, 2'b11, 32'hF000_000F, 5'd8, 4'd9);
        step();
        drive0(1'b1, 2'b00, 32'h5555_5555, 5'd1, 4'd10);
        drive1(1'b1, 2'b00, 32'h3333_3333, 5'd1, 4'd11);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", bus.out_data, 32'hFFF0_0000);
            check("stall_tag", 32'(bus.out_tag), 32'd9);
        end
        drive0(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        bus.out_ready = 1'b1;
        step();
        check("refill_src", 32'(bus.out_src), 32'h1);
        check("refill_data", bus.out_data, 32'h6666_6666);
        drive1(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        step();

        // Only in1 valid with ptr=0, then idle; ptr must stay at 0.
        drive1(1'b1, 2'b01, 32'h0000_0100, 5'd4, 4'd12);
        step();
        drive1(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        step();
        drive0(1'b1, 2'b00, 32'h0000_0003, 5'd4, 4'd13);
        drive1(1'b1, 2'b00, 32'h0000_0005, 5'd4, 4'd14);
        step();
        check("ptr_idle_src", 32'(bus.out_src), 32'h0);

        // Asynchronous reset while a result is stalled.
        drive0(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        bus.out_ready = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'h0);
        check("arst_data", bus.out_data, 32'h0);
        check("arst_tag", 32'(bus.out_tag), 32'h0);
        check("arst_src", 32'(bus.out_src), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 1'b0;
        sb.delete();
        bus.out_ready = 1'b1;
        drive0(1'b1, 2'b00, 32'h0000_0007, 5'd1, 4'd1);
        drive1(1'b1, 2'b00, 32'h0000_0009, 5'd1, 4'd2);
        step();
        check("arst_ptr_src", 32'(bus.out_src), 32'h0);
        drive0(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        drive1(1'b0, 2'b00, 32'h0, 5'd0, 4'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
